// File: rtl/fetch_ctrl.sv
// Fetch-stage control: BOOT/FETCH/HOLD/REDIRECT sequencing, memory wait timeout, stall statistics.
// Enables are combinational from state and inputs; counters and the timeout flag are registered.
module fetch_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  input  logic       imem_ready,
  input  logic       branch_taken,
  input  logic       load_use_hazard,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       if_id_flush,
  output logic       fetch_busy,
  output logic [7:0] stall_count,
  output logic       imem_timeout
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          waiting;

  always_comb begin
    state_nxt      = state;
    imem_req       = 1'b0;
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_write_en = 1'b1;
          if_id_flush = 1'b1;
          state_nxt   = imem_ready ? FETCH : REDIRECT;
        end else if (load_use_hazard) begin
          // Any instruction returned now is dropped; the same PC is refetched.
          state_nxt = HOLD;
        end else if (imem_ready) begin
          pc_write_en    = 1'b1;
          if_id_write_en = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_write_en = 1'b1;
          if_id_flush = 1'b1;
          state_nxt   = FETCH;
        end else if (!load_use_hazard) begin
          state_nxt = FETCH;
        end
      end
      REDIRECT: begin
        // Waiting out the stale in-flight response; it is discarded on arrival.
        if (branch_taken) begin
          pc_write_en = 1'b1;
          if_id_flush = 1'b1;
        end
        if (imem_ready) state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign waiting    = ((state == FETCH) || (state == REDIRECT)) && !imem_ready;
  assign fetch_busy = waiting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      wait_cnt     <= '0;
      stall_count  <= 8'd0;
      imem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!waiting)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WAIT_MAX)
        imem_timeout <= 1'b1;
      if ((state != BOOT) && !if_id_write_en && !if_id_flush && (stall_count != 8'hFF))
        stall_count <= stall_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl with a behavioural model feeding a scoreboard queue.
module tb_fetch_ctrl;

  localparam int TO = 16;
  localparam int M_BOOT = 0, M_FETCH = 1, M_HOLD = 2, M_REDIR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req, imem_ready, branch_taken, load_use_hazard;
  logic       pc_write_en, if_id_write_en, if_id_flush, fetch_busy, imem_timeout;
  logic [7:0] stall_count;

  fetch_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready),
    .branch_taken(branch_taken), .load_use_hazard(load_use_hazard),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_flush(if_id_flush), .fetch_busy(fetch_busy),
    .stall_count(stall_count), .imem_timeout(imem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit req, pcw, idw, fl, busy, to;
    int stall;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: abstract mode, consecutive-wait streak, stall total, sticky timeout.
  int m_mode, m_streak, m_stall;
  bit m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_streak = 0; m_stall = 0; m_to = 0;
  endtask

  // Apply the rules for one cycle given current inputs; push expected outputs, then advance.
  task automatic model_step(input bit br, input bit hz, input bit rdy);
    exp_t e;
    int   nxt;
    bit   in_wait;
    e.req = 0; e.pcw = 0; e.idw = 0; e.fl = 0;
    nxt = m_mode;
    if (m_mode == M_BOOT) begin
      nxt = M_FETCH;
    end else if (br) begin
      e.pcw = 1; e.fl = 1;
      if (m_mode == M_HOLD) nxt = M_FETCH;
      else nxt = rdy ? M_FETCH : M_REDIR;
    end else if (m_mode == M_FETCH) begin
      if (hz) nxt = M_HOLD;
      else if (rdy) begin e.pcw = 1; e.idw = 1; end
    end else if (m_mode == M_HOLD) begin
      nxt = hz ? M_HOLD : M_FETCH;
    end else begin
      nxt = rdy ? M_FETCH : M_REDIR;
    end
    e.req   = (m_mode == M_FETCH);
    in_wait = (m_mode == M_FETCH || m_mode == M_REDIR) && !rdy;
    e.busy  = in_wait;
    e.stall = m_stall;
    e.to    = m_to;
    q.push_back(e);
    if (m_streak >= TO) m_to = 1;
    m_streak = in_wait ? ((m_streak + 1 > TO) ? TO : m_streak + 1) : 0;
    if (m_mode != M_BOOT && !e.idw && !e.fl && m_stall < 255) m_stall++;
    m_mode = nxt;
  endtask

  task automatic drive(input bit br, input bit hz, input bit rdy);
    @(posedge clk);
    #2;
    branch_taken = br; load_use_hazard = hz; imem_ready = rdy;
    model_step(br, hz, rdy);
  endtask

  // Async reset mid-cycle: outputs must clear before any clock edge, then release into BOOT.
  task automatic do_reset(input bit rdy);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_write_en", pc_write_en, 0);
    chk("rst_if_id_write_en", if_id_write_en, 0);
    chk("rst_if_id_flush", if_id_flush, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_imem_timeout", imem_timeout, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    branch_taken = $urandom_range(0, 1); load_use_hazard = $urandom_range(0, 1);
    imem_ready = rdy;
    model_step(branch_taken, load_use_hazard, rdy);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_req", imem_req, e.req);
        chk("pc_write_en", pc_write_en, e.pcw);
        chk("if_id_write_en", if_id_write_en, e.idw);
        chk("if_id_flush", if_id_flush, e.fl);
        chk("fetch_busy", fetch_busy, e.busy);
        chk("stall_count", stall_count, e.stall);
        chk("imem_timeout", imem_timeout, e.to);
        chk("flush_write_exclusive", if_id_flush & if_id_write_en, 0);
      end
    end
  end

  initial begin : stim
    branch_taken = 0; load_use_hazard = 0; imem_ready = 1;
    model_reset();

    // Clean boot with memory always ready
    do_reset(1);
    repeat (10) drive(0, 0, 1);
    chk("boot_stall_zero", stall_count, 0);

    // Load-use hazard for two cycles: FETCH, HOLD, HOLD stalled
    drive(0, 1, 1);
    drive(0, 1, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("hazard_stall_three", stall_count, 3);

    // Branch while memory busy, then discard the late response
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);

    // Branch beats hazard
    drive(1, 1, 1);
    drive(0, 0, 1);

    // Second branch inside REDIRECT
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);

    // Memory timeout, sticky until reset
    do_reset(0);
    repeat (20) drive(0, 0, 0);
    chk("timeout_set", imem_timeout, 1);
    repeat (3) drive(0, 0, 1);
    chk("timeout_sticky", imem_timeout, 1);

    // Stall saturation, then reset in the middle of HOLD
    do_reset(1);
    drive(0, 1, 1);
    repeat (300) drive(0, 1, 1);
    chk("stall_saturated", stall_count, 255);
    do_reset(1);
    drive(0, 0, 1);
    drive(0, 0, 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset($urandom_range(0, 1));
      else if (i >= 1500 && i < 1540)
        drive(0, 0, 0);
      else
        drive($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) < 7);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: consecutive imem_ready-low wait cycles that set imem_timeout.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-005 SHALL have port imem_ready, input, 1: memory returns a valid instruction this cycle.
REQ-006 SHALL have port branch_taken, input, 1: redirect from EX.
REQ-007 SHALL have port load_use_hazard, input, 1: stall request from ID.
REQ-008 SHALL have port pc_write_en, output, 1: PC load enable to the fetch stage.
REQ-009 SHALL have port if_id_write_en, output, 1: IF/ID register load enable.
REQ-010 SHALL have port if_id_flush, output, 1: IF/ID register loads NOP.
REQ-011 SHALL have port fetch_busy, output, 1: high in FETCH or REDIRECT while imem_ready is low.
REQ-012 SHALL have port stall_count, output, 8: saturating count of stall cycles.
REQ-013 SHALL have port imem_timeout, output, 1: sticky memory-timeout flag.

Function
REQ-014 SHALL implement FSM states BOOT, FETCH, HOLD, REDIRECT, plus a registered wait counter and stall_count.
- Outputs are combinational from state and inputs.
REQ-015 BOOT SHALL drive all enables and imem_req to 0, ignore every input, and go to FETCH next cycle.
REQ-016 FETCH SHALL drive imem_req=1.
REQ-017 FETCH, imem_ready=1, no branch, no hazard, SHALL drive pc_write_en=1 and if_id_write_en=1, and stay in FETCH.
REQ-018 FETCH, imem_ready=0, no branch, SHALL drive pc_write_en=0 and if_id_write_en=0, and stay in FETCH.
REQ-019 FETCH, load_use_hazard=1, no branch, SHALL drive pc_write_en=0 and if_id_write_en=0, and go to HOLD.
- Any returned instruction is discarded.
- The same PC is refetched later.
REQ-020 HOLD SHALL drive imem_req=0 and both enables 0.
- Stays in HOLD while load_use_hazard=1.
- Goes to FETCH when load_use_hazard=0.
REQ-021 branch_taken=1 in FETCH, HOLD or REDIRECT SHALL drive pc_write_en=1, if_id_flush=1 and if_id_write_en=0.
- branch_taken has priority over load_use_hazard and imem_ready.
REQ-022 Branch in FETCH with imem_ready=0 SHALL go to REDIRECT.
- Branch in FETCH with imem_ready=1, or in HOLD, SHALL go to FETCH.
REQ-023 REDIRECT SHALL drive imem_req=0 and pc_write_en=0, if_id_write_en=0, until imem_ready=1.
- That response is discarded (no enables).
- Then goes to FETCH.
- A second branch in REDIRECT reloads the PC and stays in REDIRECT if imem_ready=0.
REQ-024 if_id_flush and if_id_write_en SHALL never both be 1.
REQ-025 The wait counter SHALL:
- increment each FETCH/REDIRECT cycle with imem_ready=0;
- clear on imem_ready=1 or on leaving those states;
- saturate at TIMEOUT.
REQ-026 imem_timeout SHALL set the cycle after the wait counter reaches TIMEOUT, and remain 1 until reset.
REQ-027 stall_count SHALL increment by 1, saturating at 255, on each non-BOOT cycle with if_id_write_en=0 and if_id_flush=0.

Reset
REQ-028 rst=1 SHALL immediately force the following regardless of clk:
- state=BOOT;
- wait counter=0, stall_count=0, imem_timeout=0;
- imem_req, pc_write_en, if_id_write_en, if_id_flush = 0.
REQ-029 Reset asserted mid-REDIRECT or mid-HOLD SHALL abandon the operation.
- After release, the first imem_req=1 SHALL occur exactly one cycle after BOOT.

Verification
REQ-030 Release reset, imem_ready tied 1 -> cycle 0 BOOT with imem_req=0; cycles 1..10 pc_write_en=if_id_write_en=1; stall_count=0.
REQ-031 FETCH, load_use_hazard=1 for 2 cycles with imem_ready=1 -> enables 0 for 3 cycles (FETCH, HOLD, HOLD); FETCH resumes; stall_count=3.
REQ-032 FETCH, imem_ready=0, branch_taken=1 for 1 cycle -> pc_write_en=1, if_id_flush=1 that cycle; REDIRECT; next imem_ready=1 (3 cycles later) discarded with no enables; then FETCH.
REQ-033 FETCH, branch_taken=1 and load_use_hazard=1 together with imem_ready=1 -> flush=1, pc_write_en=1, if_id_write_en=0; next state FETCH, not HOLD.
REQ-034 TIMEOUT=16, imem_ready held 0 in FETCH for 20 cycles -> imem_timeout rises after the 16th wait cycle, stays 1 after imem_ready returns, clears only on rst.
REQ-035 300 stall cycles -> stall_count saturates at 255; rst asserted asynchronously mid-cycle -> all outputs 0 before the next clk edge.
